ex_mem_flag_stage: RTL and testbench
====================================

EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clock port is clk, reset port is reset.
REQ-002 Parameter WIDTH, default 64: datapath width.
REQ-003 Parameter REG_ADDR, default 5: register-index width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hold every register this cycle.
REQ-007 flush  input  1  load a bubble into the stage.
REQ-008 in_valid  input  1  EX-stage instruction is real.
REQ-009 alu_result  input  WIDTH  ALU result.
REQ-010 negative, zero, overflow, carry_out  input  1 each  ALU flags.
REQ-011 set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS).
REQ-012 rd  input  REG_ADDR  destination register.
REQ-013 reg_write, mem_read, mem_write  input  1 each  downstream controls.
REQ-014 store_data  input  WIDTH  STUR data.
REQ-015 out_valid, out_reg_write, out_mem_read, out_mem_write  output  1 each  registered validity and controls.
REQ-016 out_result, out_store_data  output  WIDTH  registered data.
REQ-017 out_rd  output  REG_ADDR  registered destination.
REQ-018 flag_n, flag_z, flag_v, flag_c  output  1 each  architectural NZCV register.
REQ-019 cond_n, cond_z, cond_v, cond_c  output  1 each  bypassed NZCV for same-cycle B.cond evaluation.

Function
REQ-020 Pipeline latency SHALL be exactly one clock from inputs to out_* outputs.
REQ-021 Update condition: on a rising edge with reset=0, flush=0 and stall=0, all out_* registers SHALL load their inputs, out_valid loading in_valid.
REQ-022 Stall-only (stall=1, flush=0): every register, including NZCV, SHALL hold its value.
REQ-023 Flush: flush=1 SHALL clear out_valid, out_reg_write, out_mem_read and out_mem_write on the next edge, regardless of stall; flush has priority over stall.
REQ-024 On a flush, out_result, out_store_data and out_rd SHALL hold their previous values.
REQ-025 Whenever out_valid=0, out_reg_write, out_mem_read and out_mem_write SHALL be 0, including when in_valid=0 with set control inputs.
REQ-026 NZCV update: the flag register SHALL load {negative, zero, overflow, carry_out} only on an edge where in_valid=1, set_flags=1, stall=0 and flush=0.
REQ-027 In all other cases, NZCV SHALL hold; a flushed or invalid instruction never modifies flags.
REQ-028 Combinational bypass: cond_* SHALL equal the incoming ALU flags when in_valid=1, set_flags=1 and flush=0, and SHALL equal flag_* otherwise; stall does not affect the bypass.
REQ-029 Back-to-back flag-setting instructions SHALL each update NZCV on their own edge; the last one wins.
REQ-030 No arithmetic is performed; widths pass through unchanged.

Reset
REQ-031 Asserting reset SHALL immediately clear out_valid, all out_* controls, out_result, out_store_data, out_rd and NZCV to 0, without waiting for clk.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-033 On the first edge after deassertion, the stage SHALL obey REQ-021 to REQ-028.
REQ-034 cond_* during reset SHALL follow REQ-028 against the cleared NZCV.

Structure
REQ-035 Shared package cpu_pkg SHALL hold WIDTH, REG_ADDR and the typedef nzcv_t (packed n, z, v, c).
REQ-036 The NZCV register and bypass mux SHALL be the sub-module nzcv_register (inputs: clk, reset, load enable, flags in; outputs: flags, bypassed flags).
REQ-037 Pipeline registers SHALL be instantiated in ex_mem_flag_stage directly.

Verification
REQ-038 Reset: assert reset mid-cycle with out_valid=1 and NZCV=1111 -> all outputs 0 before the next edge.
REQ-039 Pass-through: in_valid=1, alu_result=64'h0000_0000_0000_00F0, rd=3, reg_write=1 -> next edge out_result=F0, out_rd=3, out_reg_write=1, out_valid=1.
REQ-040 Flag set and bypass: ANDS with N=1, Z=0 (set_flags=1, valid) -> cond_n=1 in the same cycle; flag_n=1 after the edge; a following ADD with set_flags=0 and Z=1 -> flag_z stays 0.
REQ-041 Stall: stall=1 for 3 cycles with changing inputs -> outputs and NZCV are constant, then update on the first unstalled edge.
REQ-042 Flush plus stall: flush=1, stall=1, mem_write=1, set_flags=1 -> next edge out_valid=0, out_mem_write=0, NZCV unchanged, cond_* equals flag_*.
REQ-043 Invalid control: in_valid=0, mem_read=1 -> out_mem_read=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and the NZCV flag type.
package cpu_pkg;
    localparam int WIDTH = 64;
    localparam int REG_ADDR = 5;
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzcv_t;
endpackage

// File: rtl/nzcv_register.sv
// nzcv_register: architectural NZCV flags plus a same-cycle bypass for B.cond.
module nzcv_register
    import cpu_pkg::nzcv_t;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  bypass,
    input  nzcv_t flags_in,
    output nzcv_t flags,
    output nzcv_t cond
);
    nzcv_t flags_d, flags_q;
    always_comb begin
        flags_d = load ? flags_in : flags_q;
        cond    = bypass ? flags_in : flags_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end
    assign flags = flags_q;
endmodule

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX/MEM pipeline register with stall, flush and NZCV ownership.
module ex_mem_flag_stage
    import cpu_pkg::nzcv_t;
#(
    parameter int WIDTH    = cpu_pkg::WIDTH,
    parameter int REG_ADDR = cpu_pkg::REG_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                negative,
    input  logic                zero,
    input  logic                overflow,
    input  logic                carry_out,
    input  logic                set_flags,
    input  logic [REG_ADDR-1:0] rd,
    input  logic                reg_write,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [WIDTH-1:0]    store_data,
    output logic                out_valid,
    output logic                out_reg_write,
    output logic                out_mem_read,
    output logic                out_mem_write,
    output logic [WIDTH-1:0]    out_result,
    output logic [WIDTH-1:0]    out_store_data,
    output logic [REG_ADDR-1:0] out_rd,
    output logic                flag_n,
    output logic                flag_z,
    output logic                flag_v,
    output logic                flag_c,
    output logic                cond_n,
    output logic                cond_z,
    output logic                cond_v,
    output logic                cond_c
);
    logic                advance;
    logic                valid_d, valid_q;
    logic [2:0]          ctrl_d, ctrl_q;
    logic [WIDTH-1:0]    result_d, result_q, store_d, store_q;
    logic [REG_ADDR-1:0] rd_d, rd_q;
    nzcv_t               flags_in, flags, cond;

    // Controls are gated by in_valid so a bubble can never carry side effects.
    always_comb begin
        advance  = ~flush & ~stall;
        valid_d  = flush ? 1'b0 : stall ? valid_q : in_valid;
        ctrl_d   = flush ? 3'b000 : stall ? ctrl_q : in_valid ? {reg_write, mem_read, mem_write} : 3'b000;
        result_d = advance ? alu_result : result_q;
        store_d  = advance ? store_data : store_q;
        rd_d     = advance ? rd : rd_q;
        flags_in = '{n: negative, z: zero, v: overflow, c: carry_out};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
        end
    end

    nzcv_register u_nzcv (
        .clk      (clk),
        .reset    (reset),
        .load     (in_valid & set_flags & advance),
        .bypass   (in_valid & set_flags & ~flush),
        .flags_in (flags_in),
        .flags    (flags),
        .cond     (cond)
    );

    assign out_valid      = valid_q;
    assign {out_reg_write, out_mem_read, out_mem_write} = ctrl_q;
    assign out_result     = result_q;
    assign out_store_data = store_q;
    assign out_rd         = rd_q;
    assign {flag_n, flag_z, flag_v, flag_c} = flags;
    assign {cond_n, cond_z, cond_v, cond_c} = cond;
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: scoreboard bench for the EX/MEM stage and NZCV bypass.
module tb_ex_mem_flag_stage;
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] result;
        logic [63:0] store;
        logic [4:0]  rd;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 0, reset = 1, stall = 0, flush = 0, in_valid = 0, set_flags = 0;
    logic        negative = 0, zero = 0, overflow = 0, carry_out = 0;
    logic        reg_write = 0, mem_read = 0, mem_write = 0;
    logic [63:0] alu_result = '0, store_data = '0;
    logic [4:0]  rd = '0;
    logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [63:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        flag_n, flag_z, flag_v, flag_c, cond_n, cond_z, cond_v, cond_c;

    int   checks = 0, errors = 0;
    exp_t model = '0;
    exp_t sb[$];

    ex_mem_flag_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out), .set_flags(set_flags), .rd(rd), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .store_data(store_data),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
        .cond_n(cond_n), .cond_z(cond_z), .cond_v(cond_v), .cond_c(cond_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".valid"}, out_valid, e.valid);
        chk({tag, ".rw"}, out_reg_write, e.rw);
        chk({tag, ".mr"}, out_mem_read, e.mr);
        chk({tag, ".mw"}, out_mem_write, e.mw);
        chk({tag, ".result"}, out_result, e.result);
        chk({tag, ".store"}, out_store_data, e.store);
        chk({tag, ".rd"}, out_rd, e.rd);
        chk({tag, ".nzcv"}, {flag_n, flag_z, flag_v, flag_c}, e.flags);
    endtask

    // Starts #1 after a rising edge, ends #1 after the next one.
    task automatic step(input string tag, input logic st, fl, iv, sf, input logic [3:0] f,
                        input logic rw, mr, mw, input logic [63:0] res, sd, input logic [4:0] r);
        logic [3:0] exp_cond;
        exp_t e;
        stall = st; flush = fl; in_valid = iv; set_flags = sf;
        {negative, zero, overflow, carry_out} = f;
        reg_write = rw; mem_read = mr; mem_write = mw;
        alu_result = res; store_data = sd; rd = r;
        #1;
        exp_cond = (iv && sf && !fl) ? f : model.flags;
        chk({tag, ".cond"}, {cond_n, cond_z, cond_v, cond_c}, exp_cond);
        if (fl) begin
            model.valid = 0; model.rw = 0; model.mr = 0; model.mw = 0;
        end else if (!st) begin
            model.valid = iv;
            model.rw = iv & rw; model.mr = iv & mr; model.mw = iv & mw;
            model.result = res; model.store = sd; model.rd = r;
            if (iv && sf) model.flags = f;
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        if (sb.size() == 0) chk({tag, ".sb_empty"}, 1, 0);
        else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic zero_inputs();
        stall = 0; flush = 0; in_valid = 0; set_flags = 0;
        {negative, zero, overflow, carry_out} = '0;
        reg_write = 0; mem_read = 0; mem_write = 0;
        alu_result = '0; store_data = '0; rd = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", '0);
        chk("reset.cond", {cond_n, cond_z, cond_v, cond_c}, 4'h0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        step("pass", 0, 0, 1, 0, 4'h0, 1, 0, 0, 64'hF0, 64'h11, 5'd3);
        step("ands", 0, 0, 1, 1, 4'b1000, 1, 0, 0, 64'h8000_0000_0000_0000, 64'h0, 5'd4);
        step("add_nosf", 0, 0, 1, 0, 4'b0100, 1, 0, 0, 64'h0, 64'h0, 5'd5);
        step("stall0", 1, 0, 1, 1, 4'b0110, 0, 1, 0, 64'hAAAA, 64'h1, 5'd7);
        step("stall1", 1, 0, 1, 1, 4'b0011, 0, 0, 1, 64'hBBBB, 64'h2, 5'd8);
        step("stall2", 1, 0, 0, 0, 4'b1111, 1, 1, 1, 64'hCCCC, 64'h3, 5'd9);
        step("unstall", 0, 0, 1, 1, 4'b0101, 0, 0, 1, 64'hDDDD, 64'h1234, 5'd10);
        step("flush_stall", 1, 1, 1, 1, 4'b1010, 0, 0, 1, 64'hEEEE, 64'h5678, 5'd11);
        step("flush", 0, 1, 1, 1, 4'b1010, 1, 1, 1, 64'hFFFF, 64'h9, 5'd12);
        step("inv_ctrl", 0, 0, 0, 1, 4'b1111, 1, 1, 1, 64'h77, 64'h88, 5'd13);
        step("b2b_a", 0, 0, 1, 1, 4'b0001, 1, 0, 0, 64'h1, 64'h0, 5'd1);
        step("b2b_b", 0, 0, 1, 1, 4'b0010, 1, 0, 0, 64'h2, 64'h0, 5'd2);
        step("ones", 0, 0, 1, 1, 4'b1111, 1, 1, 0, 64'h5555, 64'h6666, 5'd31);
        for (int i = 0; i < 40; i++)
            step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
        step("pre_rst", 0, 0, 1, 1, 4'b1111, 1, 0, 1, 64'h42, 64'h43, 5'd6);
        zero_inputs();
        stall = 1; flush = 1;
        #3;
        reset = 1;
        #1;
        model = '0;
        check_outputs("async_rst", '0);
        chk("async_rst.cond", {cond_n, cond_z, cond_v, cond_c}, 4'h0);
        @(negedge clk);
        zero_inputs();
        reset = 0;
        @(posedge clk);
        #1;
        step("post_rst", 0, 0, 1, 1, 4'b0110, 0, 1, 0, 64'h99, 64'hA, 5'd14);
        step("post_rst2", 0, 0, 0, 0, 4'b0000, 0, 1, 0, 64'h9A, 64'hB, 5'd15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
